// File: rtl/rst_seq.sv
// Staged reset sequencer: releases subsystem resets one at a time after lock,
// with per-stage ready handshakes, lock-loss restart and timeout faults.
module rst_seq #(
    parameter int N_STAGES  = 3,
    parameter int STAGE_DLY = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lock_in,
    input  logic                soft_rst_req,
    input  logic [N_STAGES-1:0] stage_rdy,
    output logic [N_STAGES-1:0] stage_rst,
    output logic                all_ready,
    output logic                fault,
    output logic [7:0]          relock_cnt,
    output logic [2:0]          state
);

    localparam int CMAX = (STAGE_DLY > TIMEOUT) ? STAGE_DLY : TIMEOUT;
    localparam int CW   = $clog2(CMAX);
    localparam int IW   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [CW-1:0] DLY_END = CW'(STAGE_DLY - 1);
    localparam logic [CW-1:0] TO_END  = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST    = IW'(N_STAGES - 1);

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_WAIT_DLY  = 3'd2,
        S_WAIT_RDY  = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t        st;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [1:0]    sync;
    logic          lock_s;
    logic          first_lock;
    logic          lock_loss;

    assign state  = st;
    assign lock_s = sync[1];

    // Lock loss only matters once the sequence has started releasing stages.
    assign lock_loss = !lock_s &&
                       (st == S_WAIT_DLY || st == S_WAIT_RDY || st == S_RUN);

    always_ff @(posedge clk) begin
        if (reset) sync <= 2'b00;
        else       sync <= {sync[0], lock_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= S_HOLD;
            stage_rst  <= '1;
            all_ready  <= 1'b0;
            fault      <= 1'b0;
            relock_cnt <= 8'd0;
            cnt        <= '0;
            idx        <= '0;
            first_lock <= 1'b0;
        end else if (soft_rst_req && st != S_HOLD) begin
            st        <= S_HOLD;
            stage_rst <= '1;
            all_ready <= 1'b0;
            fault     <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
        end else if (lock_loss) begin
            st        <= S_HOLD;
            stage_rst <= '1;
            all_ready <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
            if (first_lock && relock_cnt != 8'hFF)
                relock_cnt <= relock_cnt + 8'd1;
        end else begin
            unique case (st)
                S_HOLD: begin
                    if (cnt == DLY_END) begin
                        st  <= S_WAIT_LOCK;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        st         <= S_WAIT_DLY;
                        idx        <= '0;
                        cnt        <= '0;
                        first_lock <= 1'b1;
                    end else if (cnt == TO_END) begin
                        st        <= S_FAULT;
                        stage_rst <= '1;
                        all_ready <= 1'b0;
                        fault     <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_DLY: begin
                    if (cnt == DLY_END) begin
                        stage_rst[idx] <= 1'b0;
                        st             <= S_WAIT_RDY;
                        cnt            <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_RDY: begin
                    // Ready beats a coincident timeout.
                    if (stage_rdy[idx]) begin
                        cnt <= '0;
                        if (idx == LAST) begin
                            st        <= S_RUN;
                            all_ready <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                            st  <= S_WAIT_DLY;
                        end
                    end else if (cnt == TO_END) begin
                        st        <= S_FAULT;
                        stage_rst <= '1;
                        all_ready <= 1'b0;
                        fault     <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    cnt <= '0;
                end
                S_FAULT: begin
                    stage_rst <= '1;
                    all_ready <= 1'b0;
                    fault     <= 1'b1;
                    cnt       <= '0;
                end
                default: begin
                    st        <= S_HOLD;
                    stage_rst <= '1;
                    all_ready <= 1'b0;
                    cnt       <= '0;
                    idx       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: bring-up timing, timeouts, lock loss, priority and
// mid-sequence reset, with a scoreboard of expected output transitions.
module tb_rst_seq;

    localparam int N   = 3;
    localparam int DLY = 4;
    localparam int TO  = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         lock_in;
    logic         soft_rst_req;
    logic [N-1:0] stage_rdy;
    logic [N-1:0] stage_rst;
    logic         all_ready;
    logic         fault;
    logic [7:0]   relock_cnt;
    logic [2:0]   state;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_relock = 0;

    typedef struct {
        int           cyc;
        logic [N-1:0] rst;
        logic         rdy;
    } ev_t;

    ev_t exp_q[$];

    always #5 clk = ~clk;

    rst_seq #(
        .N_STAGES (N),
        .STAGE_DLY(DLY),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lock_in     (lock_in),
        .soft_rst_req(soft_rst_req),
        .stage_rdy   (stage_rdy),
        .stage_rst   (stage_rst),
        .all_ready   (all_ready),
        .fault       (fault),
        .relock_cnt  (relock_cnt),
        .state       (state)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // The edge that samples reset high is cycle 0.
    task automatic do_reset();
        reset        = 1'b1;
        soft_rst_req = 1'b0;
        tick();
        reset      = 1'b0;
        exp_relock = 0;
    endtask

    task automatic run_sequence(input string tag);
        logic [N:0] prev;
        logic [N:0] cur;
        ev_t        e;
        exp_q.delete();
        exp_q.push_back('{9,  3'b110, 1'b0});
        exp_q.push_back('{14, 3'b100, 1'b0});
        exp_q.push_back('{19, 3'b000, 1'b0});
        exp_q.push_back('{20, 3'b000, 1'b1});
        prev = {stage_rst, all_ready};
        for (int c = 1; c <= 30; c++) begin
            tick();
            cur = {stage_rst, all_ready};
            if (cur !== prev) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s unexpected change cycle %0d got %b",
                             tag, c, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (c != e.cyc || cur !== {e.rst, e.rdy}) begin
                        n_fail++;
                        $display("FAIL %s edge got cyc %0d %b need cyc %0d %b",
                                 tag, c, cur, e.cyc, {e.rst, e.rdy});
                    end
                end
                prev = cur;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s missing %0d transitions", tag, exp_q.size());
        end
        n_checks++;
        if (fault !== 1'b0 || relock_cnt !== 8'd0 || state !== 3'd4) begin
            n_fail++;
            $display("FAIL %s end got f=%b rc=%0d st=%0d need 0 0 4",
                     tag, fault, relock_cnt, state);
        end
    endtask

    task automatic test_reset();
        lock_in   = 1'b0;
        stage_rdy = '0;
        do_reset();
        n_checks++;
        if (stage_rst !== 3'b111 || all_ready !== 1'b0 || fault !== 1'b0 ||
            relock_cnt !== 8'd0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset got %b %b %b %0d %0d need 111 0 0 0 0",
                     stage_rst, all_ready, fault, relock_cnt, state);
        end
    endtask

    task automatic test_bringup();
        lock_in   = 1'b1;
        stage_rdy = 3'b111;
        do_reset();
        run_sequence("bringup");
    endtask

    task automatic test_lock_timeout();
        lock_in   = 1'b0;
        stage_rdy = 3'b111;
        do_reset();
        tick(67);
        n_checks++;
        if (state !== 3'd1 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_to_pre got st=%0d f=%b need 1 0", state, fault);
        end
        tick();
        n_checks++;
        if (state !== 3'd5 || fault !== 1'b1 || stage_rst !== 3'b111) begin
            n_fail++;
            $display("FAIL lock_to got st=%0d f=%b rst=%b need 5 1 111",
                     state, fault, stage_rst);
        end
        lock_in = 1'b1;
        tick(6);
        n_checks++;
        if (state !== 3'd5 || fault !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_sticky got st=%0d f=%b need 5 1", state, fault);
        end
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        n_checks++;
        if (state !== 3'd0 || fault !== 1'b0 || stage_rst !== 3'b111) begin
            n_fail++;
            $display("FAIL fault_clear got st=%0d f=%b rst=%b need 0 0 111",
                     state, fault, stage_rst);
        end
    endtask

    task automatic test_stage_stall();
        lock_in   = 1'b1;
        stage_rdy = 3'b101;
        do_reset();
        tick(14);
        n_checks++;
        if (stage_rst !== 3'b100 || state !== 3'd3) begin
            n_fail++;
            $display("FAIL stall_wait got rst=%b st=%0d need 100 3",
                     stage_rst, state);
        end
        tick(63);
        n_checks++;
        if (stage_rst !== 3'b100 || state !== 3'd3 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_pre got rst=%b st=%0d f=%b need 100 3 0",
                     stage_rst, state, fault);
        end
        tick();
        n_checks++;
        if (stage_rst !== 3'b111 || state !== 3'd5 || fault !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_to got rst=%b st=%0d f=%b need 111 5 1",
                     stage_rst, state, fault);
        end
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
    endtask

    task automatic lock_drop_cycle(input string tag);
        int k;
        lock_in = 1'b0;
        tick(2);
        n_checks++;
        if (all_ready !== 1'b1 || state !== 3'd4) begin
            n_fail++;
            $display("FAIL %s sync_lag got rdy=%b st=%0d need 1 4",
                     tag, all_ready, state);
        end
        tick();
        exp_relock = (exp_relock < 255) ? exp_relock + 1 : 255;
        n_checks++;
        if (stage_rst !== 3'b111 || all_ready !== 1'b0 || state !== 3'd0 ||
            relock_cnt !== 8'(exp_relock)) begin
            n_fail++;
            $display("FAIL %s loss got rst=%b rdy=%b st=%0d rc=%0d need 111 0 0 %0d",
                     tag, stage_rst, all_ready, state, relock_cnt, exp_relock);
        end
        tick(7);
        lock_in = 1'b1;
        k = 0;
        while (all_ready !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        n_checks++;
        if (all_ready !== 1'b1 || stage_rst !== 3'b000) begin
            n_fail++;
            $display("FAIL %s replay timeout got rdy=%b rst=%b need 1 000",
                     tag, all_ready, stage_rst);
        end
    endtask

    task automatic test_lock_loss();
        lock_in   = 1'b1;
        stage_rdy = 3'b111;
        do_reset();
        tick(25);
        lock_drop_cycle("lockloss");
    endtask

    task automatic test_relock_saturate();
        for (int i = 1; i < 300; i++) lock_drop_cycle("relock_sat");
        n_checks++;
        if (relock_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL relock_sat final got %0d need 255", relock_cnt);
        end
    endtask

    task automatic test_priority();
        lock_in   = 1'b1;
        stage_rdy = 3'b111;
        do_reset();
        tick(25);
        lock_in = 1'b0;
        tick(2);
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        lock_in      = 1'b1;
        n_checks++;
        if (state !== 3'd0 || relock_cnt !== 8'd0 || stage_rst !== 3'b111) begin
            n_fail++;
            $display("FAIL prio_soft_loss got st=%0d rc=%0d rst=%b need 0 0 111",
                     state, relock_cnt, stage_rst);
        end
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        tick(2);
        n_checks++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL prio_hold_len got st=%0d need 0", state);
        end
        tick();
        n_checks++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL prio_hold_exit got st=%0d need 1", state);
        end
    endtask

    task automatic test_reset_mid();
        lock_in   = 1'b1;
        stage_rdy = 3'b101;
        do_reset();
        tick(15);
        n_checks++;
        if (state !== 3'd3 || stage_rst !== 3'b100) begin
            n_fail++;
            $display("FAIL mid_pre got st=%0d rst=%b need 3 100", state, stage_rst);
        end
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        stage_rdy = 3'b111;
        n_checks++;
        if (stage_rst !== 3'b111 || all_ready !== 1'b0 || fault !== 1'b0 ||
            relock_cnt !== 8'd0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_reset got %b %b %b %0d %0d need 111 0 0 0 0",
                     stage_rst, all_ready, fault, relock_cnt, state);
        end
        run_sequence("mid_replay");
    endtask

    initial begin
        reset        = 1'b1;
        lock_in      = 1'b0;
        soft_rst_req = 1'b0;
        stage_rdy    = '0;
        tick(2);
        test_reset();
        test_bringup();
        test_lock_timeout();
        test_stage_stall();
        test_lock_loss();
        test_relock_saturate();
        test_priority();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
